muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequences the multi-cycle multiplier and divider for MULT/MULTU/DIV/DIVU in the EX stage.
//  Decodes alucontrol, launches the unit and holds the pipeline (stall_o) until the result is ready.
//  Then issues a single-cycle HI/LO write.
//  Sits between EX-stage decode (alucontrol from aludefines.vh), the mul/div units and the HI/LO register.
// PARAMETERS
//  MUL_LAT  2  multiplier latency, start pulse -> mul_result valid, cycles; legal 1..(2**CNT_W-1)
//  CNT_W    4  width of latency counter
// PORTS
//  clk          in   1   clock, rising edge
//  resetn       in   1   async active-low reset
//  op_valid     in   1   EX holds a valid instruction
//  alucontrol   in   5   EX ALU op; only ALU_MULT/MULTU/DIV/DIVU act here
//  flush        in   1   exception/pipeline flush, kills EX instruction
//  b_zero       in   1   EX divisor operand == 0
//  mul_start    out  1   1-cycle pulse; multiplier latches EX operands
//  mul_signed   out  1   signed multiply select, valid with mul_start
//  mul_result   in   64  product, valid exactly MUL_LAT cycles after mul_start
//  div_start    out  1   1-cycle pulse; divider latches EX operands
//  div_signed   out  1   signed divide select, valid with div_start
//  div_cancel   out  1   1-cycle pulse aborting the divider
//  div_done     in   1   1-cycle pulse, div_q/div_r valid
//  div_q        in   32  quotient
//  div_r        in   32  remainder
//  stall_o      out  1   freeze IF..EX
//  busy         out  1   state != IDLE
//  hilo_we      out  1   write HI and LO this cycle
//  hi_o         out  32  HI write data
//  lo_o         out  32  LO write data
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; all outputs 0, including hi_o/lo_o.
//  FSM states: IDLE, MUL_WAIT, DIV_WAIT, DONE.
//  Flush has top priority in every state:
//   - Next state is IDLE.
//   - No hilo_we.
//   - div_cancel pulses if the state is DIV_WAIT.
//   - In IDLE, flush blocks any start.
//  IDLE:
//   - op_valid & MULT/MULTU: mul_start=1, mul_signed=(MULT), cnt<=MUL_LAT-1, next state MUL_WAIT.
//   - op_valid & DIV/DIVU & !b_zero: div_start=1, div_signed=(DIV), next state DIV_WAIT.
//   - op_valid & DIV/DIVU & b_zero: no start, no write (HI/LO keep old values), no stall.
//  stall_o: combinationally 1 in the accept cycle (IDLE with a start), and throughout MUL_WAIT and DIV_WAIT.
//  stall_o is 0 in IDLE without a start and in DONE.
//  MUL_WAIT: cnt decrements. When cnt==0 (mul_result valid):
//   - hi_o<=mul_result[63:32], lo_o<=mul_result[31:0].
//   - Next state DONE.
//  DIV_WAIT: on div_done, hi_o<=div_r, lo_o<=div_q, next state DONE. There is no timeout.
//  DONE:
//   - hilo_we=1 for exactly 1 cycle.
//   - Pipeline advances this cycle.
//   - op_valid/alucontrol are ignored: the same instruction is still visible and must not restart.
//   - Next state IDLE.
//  Latency, MULT accept -> hilo_we: MUL_LAT+1 cycles. DIV: div_done cycle +1.
//  Back-to-back mul/div ops: the second op is accepted in IDLE, 1 cycle after DONE.
//  hi_o/lo_o hold their last value outside DONE.
//  mul_start/div_start/div_cancel are never asserted in the same cycle.
//  Async reset mid-operation: returns to IDLE immediately; no div_cancel; the divider is reset by the same resetn.
// TESTING
//  1. MULT, MUL_LAT=2, mul_result=64'hFFFF_FFFF_FFFF_FFFE -> stall 3 cycles; hilo_we in cycle 4 with hi=FFFF_FFFF, lo=FFFF_FFFE.
//  2. DIVU, div_done 33 cycles after div_start, q=7, r=3 -> stall until done; hilo_we 1 cycle later with hi=3, lo=7; op_valid held in DONE causes no restart.
//  3. DIV with b_zero=1 -> no div_start, stall_o=0, hilo_we stays 0.
//  4. flush in DIV_WAIT cycle 5 -> div_cancel pulse, state IDLE, no hilo_we; a later div_done is ignored.
//  5. flush coincident with DONE -> hilo_we=0. MULT then DIVU back-to-back -> two hilo_we pulses, second div_start 1 cycle after first DONE.
//  6. resetn low during MUL_WAIT -> all outputs 0 asynchronously; op accepted normally after release.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Handshake bundle between the EX-stage mul/div sequencer and the multiplier/divider units.
// The master (sequencer) launches and cancels operations; the slave (units) returns results.
interface muldiv_ctrl_if;
  logic        mul_start;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic        div_cancel;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

  modport master (
    output mul_start, mul_signed, div_start, div_signed, div_cancel,
    input  mul_result, div_done, div_q, div_r
  );

  modport slave (
    input  mul_start, mul_signed, div_start, div_signed, div_cancel,
    output mul_result, div_done, div_q, div_r
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer: launches mul/div, stalls IF..EX, then issues one HI/LO write.
// Latency: MULT hilo_we MUL_LAT+1 cycles after accept, DIV one cycle after div_done; stall_o holds the pipe meanwhile.
module muldiv_ctrl #(
  parameter int         MUL_LAT   = 2,
  parameter int         CNT_W     = 4,
  parameter logic [4:0] ALU_MULT  = 5'h0A,
  parameter logic [4:0] ALU_MULTU = 5'h0B,
  parameter logic [4:0] ALU_DIV   = 5'h0C,
  parameter logic [4:0] ALU_DIVU  = 5'h0D
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              op_valid,
  input  logic [4:0]        alucontrol,
  input  logic              flush,
  input  logic              b_zero,
  muldiv_ctrl_if.master     mdu,
  output logic              stall_o,
  output logic              busy,
  output logic              hilo_we,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_mul;
  logic             is_div;
  logic             mul_fire;
  logic             div_fire;
  logic             mul_sgn;
  logic             div_sgn;
  logic             cancel;

  // Gating with resetn keeps every output low while reset is asserted, even with op_valid high.
  assign is_mul = resetn && op_valid && (alucontrol == ALU_MULT || alucontrol == ALU_MULTU);
  assign is_div = resetn && op_valid && (alucontrol == ALU_DIV  || alucontrol == ALU_DIVU);

  always_comb begin
    state_nxt = state;
    mul_fire  = 1'b0;
    mul_sgn   = 1'b0;
    div_fire  = 1'b0;
    div_sgn   = 1'b0;
    cancel    = 1'b0;
    hilo_we   = 1'b0;
    case (state)
      IDLE: begin
        if (!flush) begin
          if (is_mul) begin
            mul_fire  = 1'b1;
            mul_sgn   = (alucontrol == ALU_MULT);
            state_nxt = MUL_WAIT;
          end else if (is_div && !b_zero) begin
            div_fire  = 1'b1;
            div_sgn   = (alucontrol == ALU_DIV);
            state_nxt = DIV_WAIT;
          end
        end
      end
      MUL_WAIT: begin
        if (flush)            state_nxt = IDLE;
        else if (cnt == '0)   state_nxt = DONE;
      end
      DIV_WAIT: begin
        if (flush) begin
          cancel    = 1'b1;
          state_nxt = IDLE;
        end else if (mdu.div_done) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // The finished instruction is still in EX here, so op_valid must not relaunch it.
        hilo_we   = !flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mdu.mul_start  = mul_fire;
  assign mdu.mul_signed = mul_sgn;
  assign mdu.div_start  = div_fire;
  assign mdu.div_signed = div_sgn;
  assign mdu.div_cancel = cancel;

  assign stall_o = mul_fire || div_fire || (state == MUL_WAIT) || (state == DIV_WAIT);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      state <= state_nxt;
      if (mul_fire)
        cnt <= CNT_W'(MUL_LAT - 1);
      else if (state == MUL_WAIT && cnt != '0)
        cnt <= cnt - CNT_W'(1);

      if (state == MUL_WAIT && !flush && cnt == '0) begin
        hi_o <= mdu.mul_result[63:32];
        lo_o <= mdu.mul_result[31:0];
      end else if (state == DIV_WAIT && !flush && mdu.div_done) begin
        hi_o <= mdu.div_r;
        lo_o <= mdu.div_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: table of single-op vectors plus hand sequences for flush, back-to-back and reset.
module tb_muldiv_ctrl;
  localparam int         MUL_LAT = 2;
  localparam logic [4:0] OP_MULT  = 5'h0A;
  localparam logic [4:0] OP_MULTU = 5'h0B;
  localparam logic [4:0] OP_DIV   = 5'h0C;
  localparam logic [4:0] OP_DIVU  = 5'h0D;
  localparam logic [4:0] OP_ADD   = 5'h01;
  localparam logic [63:0] JUNK64  = 64'hDEAD_BEEF_0BAD_F00D;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0;
  logic [4:0]  alucontrol = '0;
  logic        flush = 1'b0;
  logic        b_zero = 1'b0;
  logic        stall_o;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  muldiv_ctrl_if mdu ();

  muldiv_ctrl #(
    .MUL_LAT(MUL_LAT), .CNT_W(4),
    .ALU_MULT(OP_MULT), .ALU_MULTU(OP_MULTU), .ALU_DIV(OP_DIV), .ALU_DIVU(OP_DIVU)
  ) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .alucontrol(alucontrol),
    .flush(flush), .b_zero(b_zero), .mdu(mdu), .stall_o(stall_o), .busy(busy),
    .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic        bz;
    logic [63:0] mres;
    logic [31:0] q;
    logic [31:0] r;
    int          ddly;
    int          exp_stalls;
    int          exp_we_at;
    int          exp_nwe;
    int          exp_nms;
    int          exp_nds;
    logic        exp_sgn;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[7];
  int   ntests = 0;
  int   nfail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
  task automatic drive(input logic ov, input logic [4:0] op, input logic bz, input logic fl,
                       input logic [63:0] mres, input logic dd, input logic [31:0] q, input logic [31:0] r);
    @(negedge clk);
    op_valid       = ov;
    alucontrol     = op;
    b_zero         = bz;
    flush          = fl;
    mdu.mul_result = mres;
    mdu.div_done   = dd;
    mdu.div_q      = q;
    mdu.div_r      = r;
    #1;
  endtask

  task automatic idle_cyc();
    drive(1'b0, OP_ADD, 1'b0, 1'b0, JUNK64, 1'b0, 32'hBAD0_0BAD, 32'h0BAD_BAD0);
  endtask

  // Models a pipeline that advances whenever stall_o is low, and units that present data only in the valid cycle.
  task automatic run_op(input vec_t v, output int stalls, output int we_at, output int nwe,
                        output int nms, output int nds, output logic sgn);
    int          start_c;
    int          drop_c;
    logic        ov;
    logic [63:0] mr;
    logic        dd;
    start_c = -1; drop_c = -1; ov = 1'b1;
    stalls = 0; we_at = -1; nwe = 0; nms = 0; nds = 0; sgn = 1'b0;
    for (int c = 0; c < 80; c++) begin
      mr = (start_c >= 0 && c == start_c + MUL_LAT) ? v.mres : JUNK64;
      dd = (start_c >= 0 && c == start_c + v.ddly);
      drive(ov, v.op, v.bz, 1'b0, mr, dd, dd ? v.q : 32'hBAD0_0BAD, dd ? v.r : 32'h0BAD_BAD0);
      if (stall_o) stalls++;
      if (mdu.mul_start) begin nms++; if (start_c < 0) start_c = c; sgn = mdu.mul_signed; end
      if (mdu.div_start) begin nds++; if (start_c < 0) start_c = c; sgn = mdu.div_signed; end
      if (hilo_we) begin nwe++; if (we_at < 0) we_at = c; end
      if (ov && !stall_o) begin ov = 1'b0; drop_c = c; end
      if (drop_c >= 0 && c >= drop_c + 3) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   stalls, we_at, nwe, nms, nds, ncancel, nwe_seq;
    logic sgn;

    vecs[0] = '{OP_MULT,  1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0, 32'h0, 0,  3,  3, 1, 1, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{OP_MULTU, 1'b0, 64'h0000_0001_2345_6789, 32'h0, 32'h0, 0,  3,  3, 1, 1, 0, 1'b0, 32'h0000_0001, 32'h2345_6789};
    vecs[2] = '{OP_DIVU,  1'b0, 64'h0, 32'd7, 32'd3, 33, 34, 34, 1, 0, 1, 1'b0, 32'd3, 32'd7};
    vecs[3] = '{OP_DIV,   1'b0, 64'h0, 32'hFFFF_FFFE, 32'd1, 1, 2, 2, 1, 0, 1, 1'b1, 32'd1, 32'hFFFF_FFFE};
    vecs[4] = '{OP_DIV,   1'b1, 64'h0, 32'd9, 32'd9, 1, 0, -1, 0, 0, 0, 1'b0, 32'd1, 32'hFFFF_FFFE};
    vecs[5] = '{OP_ADD,   1'b0, 64'h0, 32'd9, 32'd9, 1, 0, -1, 0, 0, 0, 1'b0, 32'd1, 32'hFFFF_FFFE};
    vecs[6] = '{OP_DIVU,  1'b1, 64'h0, 32'd9, 32'd9, 1, 0, -1, 0, 0, 0, 1'b0, 32'd1, 32'hFFFF_FFFE};

    mdu.mul_result = JUNK64; mdu.div_done = 1'b0; mdu.div_q = '0; mdu.div_r = '0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", hilo_we, 0);
    chk("rst_hilo", {hi_o, lo_o}, 0);
    chk("rst_starts", {mdu.mul_start, mdu.div_start, mdu.div_cancel}, 0);
    @(negedge clk); resetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i], stalls, we_at, nwe, nms, nds, sgn);
      chk($sformatf("v%0d_stalls", i), stalls, vecs[i].exp_stalls);
      chk($sformatf("v%0d_we_at", i), we_at, vecs[i].exp_we_at);
      chk($sformatf("v%0d_nwe", i), nwe, vecs[i].exp_nwe);
      chk($sformatf("v%0d_mul_starts", i), nms, vecs[i].exp_nms);
      chk($sformatf("v%0d_div_starts", i), nds, vecs[i].exp_nds);
      chk($sformatf("v%0d_signed", i), sgn, vecs[i].exp_sgn);
      chk($sformatf("v%0d_hi", i), hi_o, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo_o, vecs[i].exp_lo);
    end

    // Flush in DIV_WAIT: one cancel, later div_done ignored, HI/LO untouched
    ncancel = 0; nwe_seq = 0;
    drive(1'b1, OP_DIVU, 1'b0, 1'b0, JUNK64, 1'b0, 32'h0, 32'h0);
    chk("fl_div_start", mdu.div_start, 1);
    for (int c = 1; c < 5; c++) begin
      drive(1'b1, OP_DIVU, 1'b0, 1'b0, JUNK64, 1'b0, 32'h0, 32'h0);
      if (mdu.div_cancel) ncancel++;
    end
    drive(1'b1, OP_DIVU, 1'b0, 1'b1, JUNK64, 1'b0, 32'h0, 32'h0);
    chk("fl_cancel", mdu.div_cancel, 1);
    chk("fl_no_start", {mdu.mul_start, mdu.div_start}, 0);
    if (mdu.div_cancel) ncancel++;
    idle_cyc();
    chk("fl_busy_after", busy, 0);
    chk("fl_stall_after", stall_o, 0);
    if (mdu.div_cancel) ncancel++;
    drive(1'b0, OP_ADD, 1'b0, 1'b0, JUNK64, 1'b1, 32'd55, 32'd66);
    if (hilo_we) nwe_seq++;
    for (int c = 0; c < 3; c++) begin
      idle_cyc();
      if (hilo_we) nwe_seq++;
      if (mdu.div_cancel) ncancel++;
    end
    chk("fl_cancel_count", ncancel, 1);
    chk("fl_no_we", nwe_seq, 0);
    chk("fl_hilo_kept", {hi_o, lo_o}, {32'd1, 32'hFFFF_FFFE});

    // Flush coincident with DONE suppresses the write
    drive(1'b1, OP_MULT, 1'b0, 1'b0, JUNK64, 1'b0, 32'h0, 32'h0);
    drive(1'b1, OP_MULT, 1'b0, 1'b0, JUNK64, 1'b0, 32'h0, 32'h0);
    drive(1'b1, OP_MULT, 1'b0, 1'b0, 64'h0000_0002_0000_0003, 1'b0, 32'h0, 32'h0);
    drive(1'b1, OP_MULT, 1'b0, 1'b1, JUNK64, 1'b0, 32'h0, 32'h0);
    chk("fd_busy_done", busy, 1);
    chk("fd_no_we", hilo_we, 0);
    idle_cyc();
    chk("fd_idle", {busy, hilo_we, stall_o}, 0);

    // MULT then DIVU back-to-back
    nwe_seq = 0;
    drive(1'b1, OP_MULT, 1'b0, 1'b0, JUNK64, 1'b0, 32'h0, 32'h0);
    drive(1'b1, OP_MULT, 1'b0, 1'b0, JUNK64, 1'b0, 32'h0, 32'h0);
    drive(1'b1, OP_MULT, 1'b0, 1'b0, 64'h0000_00AA_0000_00BB, 1'b0, 32'h0, 32'h0);
    drive(1'b1, OP_MULT, 1'b0, 1'b0, JUNK64, 1'b0, 32'h0, 32'h0);
    chk("bb_we1", hilo_we, 1);
    chk("bb_hilo1", {hi_o, lo_o}, {32'h0000_00AA, 32'h0000_00BB});
    chk("bb_no_restart", {mdu.mul_start, stall_o}, 0);
    if (hilo_we) nwe_seq++;
    drive(1'b1, OP_DIVU, 1'b0, 1'b0, JUNK64, 1'b0, 32'h0, 32'h0);
    chk("bb_div_start", {mdu.div_start, stall_o}, 2'b11);
    drive(1'b1, OP_DIVU, 1'b0, 1'b0, JUNK64, 1'b1, 32'h11, 32'h22);
    if (hilo_we) nwe_seq++;
    drive(1'b1, OP_DIVU, 1'b0, 1'b0, JUNK64, 1'b0, 32'h0, 32'h0);
    if (hilo_we) nwe_seq++;
    chk("bb_we2", hilo_we, 1);
    chk("bb_hilo2", {hi_o, lo_o}, {32'h22, 32'h11});
    idle_cyc();
    if (hilo_we) nwe_seq++;
    chk("bb_we_count", nwe_seq, 2);

    // Async reset in MUL_WAIT clears everything immediately
    drive(1'b1, OP_MULT, 1'b0, 1'b0, JUNK64, 1'b0, 32'h0, 32'h0);
    drive(1'b1, OP_MULT, 1'b0, 1'b0, JUNK64, 1'b0, 32'h0, 32'h0);
    chk("ar_busy_before", busy, 1);
    resetn = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_stall", stall_o, 0);
    chk("ar_hilo", {hi_o, lo_o}, 0);
    chk("ar_pulses", {hilo_we, mdu.mul_start, mdu.div_start, mdu.div_cancel}, 0);
    idle_cyc();
    @(negedge clk); resetn = 1'b1;
    run_op(vecs[0], stalls, we_at, nwe, nms, nds, sgn);
    chk("ar_post_stalls", stalls, 3);
    chk("ar_post_we_at", we_at, 3);
    chk("ar_post_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
